// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte slave: synchronizes sclk/cs_n/mosi into the clk domain and
// shifts bytes MSB first, with a registered byte-complete strobe for the next stage.
module spi_slave_byte #(
    parameter int SYNC_STAGES = 2,
    parameter int DONE_WIDTH  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       cycle_done,
    output logic       frame_err,
    output logic       busy,
    output logic [1:0] state_dbg
);

    // Downstream contract: rx_byte is valid from one clk before cycle_done rises
    // until the next byte completes; tx_byte sampled at the cycle_done rise is
    // captured once cycle_done drops (LOAD). There is no back-pressure.
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2, LOAD = 2'd3} state_t;

    localparam logic [2:0] DONE_LAST = 3'(DONE_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, fill;
    logic sclk_s, cs_s, mosi_s, sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise, sel;

    state_t     state, state_nx;
    logic [2:0] bit_cnt, cnt_nx, done_cnt, done_cnt_nx;
    logic [7:0] rx_sr, rx_sr_nx, tx_sr, tx_sr_nx, rx_byte_nx;
    logic       end_pend, end_pend_nx, err_nx, busy_nx, armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;
    // sclk edges count only if cs_n was low on the previous sample, so an 8th
    // rise coincident with the cs_n rise still completes the byte.
    assign sel       = ~cs_d;

    always_comb begin
        state_nx    = state;
        cnt_nx      = bit_cnt;
        rx_sr_nx    = rx_sr;
        tx_sr_nx    = tx_sr;
        rx_byte_nx  = rx_byte;
        done_cnt_nx = done_cnt;
        end_pend_nx = end_pend;
        err_nx      = frame_err;
        case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    tx_sr_nx = tx_byte;
                    cnt_nx   = 3'd0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise && sel) begin
                    rx_sr_nx = {rx_sr[6:0], mosi_s};
                    cnt_nx   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte_nx  = {rx_sr[6:0], mosi_s};
                        done_cnt_nx = 3'd0;
                        end_pend_nx = cs_rise;
                        state_nx    = DONE;
                    end
                end else if (sclk_fall && sel && bit_cnt != 3'd0) begin
                    // The trailing fall of a byte's last bit is skipped so the
                    // freshly loaded MSB stays on miso.
                    tx_sr_nx = {tx_sr[6:0], 1'b0};
                end
                if (cs_rise && state_nx == SHIFT) begin
                    state_nx = IDLE;
                    if (cnt_nx != 3'd0) err_nx = 1'b1;
                end
            end
            DONE: begin
                done_cnt_nx = done_cnt + 3'd1;
                if (cs_rise) end_pend_nx = 1'b1;
                if (done_cnt == DONE_LAST)
                    state_nx = (end_pend || cs_rise) ? IDLE : LOAD;
            end
            LOAD: begin
                if (cs_rise) begin
                    state_nx = IDLE;
                end else begin
                    tx_sr_nx = tx_byte;
                    state_nx = SHIFT;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == SHIFT && cnt_nx != 3'd0) || state_nx == DONE || state_nx == LOAD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            rx_sr      <= 8'h00;
            tx_sr      <= 8'h00;
            rx_byte    <= 8'h00;
            done_cnt   <= 3'd0;
            end_pend   <= 1'b0;
            frame_err  <= 1'b0;
            cycle_done <= 1'b0;
            busy       <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= cnt_nx;
            rx_sr      <= rx_sr_nx;
            tx_sr      <= tx_sr_nx;
            rx_byte    <= rx_byte_nx;
            done_cnt   <= done_cnt_nx;
            end_pend   <= end_pend_nx;
            frame_err  <= err_nx;
            cycle_done <= (state == DONE);
            busy       <= busy_nx;
            // A frame already running at reset release is ignored until cs_n
            // has been genuinely sampled high.
            armed      <= armed | (fill[SYNC_STAGES-1] & cs_s);
        end
    end

    assign miso_oe   = armed & ~cs_s;
    assign miso      = miso_oe & tx_sr[7];
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Randomized and directed bench for spi_slave_byte: a master driver, a
// cycle_done monitor with an expected-byte queue, and a pass/fail summary.
module tb_spi_slave_byte;

    localparam int SS = 2;
    localparam int DW = 2;

    logic       clk, rst, sclk, cs_n, mosi;
    logic       miso, miso_oe, cycle_done, frame_err, busy;
    logic [7:0] tx_byte, rx_byte;
    logic [1:0] state_dbg;

    spi_slave_byte #(.SYNC_STAGES(SS), .DONE_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_byte(tx_byte), .rx_byte(rx_byte),
        .cycle_done(cycle_done), .frame_err(frame_err), .busy(busy),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_checks = 0;
    int n_bad = 0;
    int n_pulses = 0;
    int run_len = 0;
    logic prev_cd = 1'b0;
    logic [7:0] prev_rx = 8'h00;
    logic exp_err = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] fm_q[$];
    logic [7:0] ft_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: each cycle_done pulse must carry the next expected byte,
    // last exactly DW cycles, and follow a stable rx_byte
    always @(negedge clk) begin
        if (!rst) begin
            run_len = 0;
        end else if (cycle_done && !prev_cd) begin
            n_pulses++;
            if (exp_q.size() == 0) check("spurious_done", 1, 0);
            else check("rx_byte", rx_byte, exp_q.pop_front());
            check("rx_stable", rx_byte, prev_rx);
            if (tx_q.size() > 0) tx_byte = tx_q.pop_front();
            run_len = 1;
        end else if (cycle_done) begin
            run_len++;
        end else if (prev_cd) begin
            check("done_width", run_len, DW);
        end
        prev_cd = cycle_done;
        prev_rx = rx_byte;
    end

    // driver: send the top nbits of m, MSB first, sampling miso before each rise
    task automatic spi_bits(input logic [7:0] m, input int nbits, input bit stop_high,
                            output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = m[7-i];
            repeat (8) @(negedge clk);
            got[7-i] = miso;
            sclk = 1'b1;
            if (i == nbits - 1 && stop_high) return;
            repeat ((i == 7) ? 12 : 8) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame();
        logic [7:0] got;
        int p0;
        p0 = n_pulses;
        tx_byte = ft_q[0];
        for (int k = 1; k < ft_q.size(); k++) tx_q.push_back(ft_q[k]);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        check("miso_oe_on", miso_oe, 1);
        check("busy_at_start", busy, 0);
        for (int k = 0; k < fm_q.size(); k++) begin
            exp_q.push_back(fm_q[k]);
            spi_bits(fm_q[k], 8, 1'b0, got);
            check("miso_byte", got, ft_q[k]);
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        check("pulse_count", n_pulses - p0, fm_q.size());
        check("rx_last", rx_byte, fm_q[fm_q.size()-1]);
        check("miso_oe_off", miso_oe, 0);
        check("busy_off", busy, 0);
        check("frame_err", frame_err, exp_err);
        tx_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] got, rx0, b;
        int p0, len;
        bit busy_seen;
        rst = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_byte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_cycle_done", cycle_done, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_state", state_dbg, 2'd0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // single byte: tx 0xA5 out, 0x01 in
        fm_q.delete(); ft_q.delete();
        fm_q.push_back(8'h01); ft_q.push_back(8'hA5);
        run_frame();

        // five-byte frame, tx advanced on each strobe
        fm_q.delete(); ft_q.delete();
        fm_q.push_back(8'h01); fm_q.push_back(8'h00); fm_q.push_back(8'h02);
        fm_q.push_back(8'h00); fm_q.push_back(8'h03);
        ft_q.push_back(8'hEE);
        for (int n = 0; n < 4; n++) ft_q.push_back(8'(8'h10 + n));
        run_frame();

        // cs_n rise coincident with the 8th sclk rise
        p0 = n_pulses;
        b = 8'(($urandom_range(0, 255)));
        tx_byte = b;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        exp_q.push_back(8'hFF);
        spi_bits(8'hFF, 8, 1'b1, got);
        cs_n = 1'b1;
        repeat (20) @(negedge clk);
        sclk = 1'b0;
        repeat (10) @(negedge clk);
        check("coinc_miso", got, b);
        check("coinc_pulses", n_pulses - p0, 1);
        check("coinc_rx", rx_byte, 8'hFF);
        check("coinc_err", frame_err, 0);
        check("coinc_state", state_dbg, 2'd0);

        // random frames
        for (int f = 0; f < 4; f++) begin
            fm_q.delete(); ft_q.delete();
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                fm_q.push_back(8'($urandom_range(0, 255)));
                ft_q.push_back(8'($urandom_range(0, 255)));
            end
            run_frame();
        end

        // sclk activity with cs_n high is ignored
        p0 = n_pulses; rx0 = rx_byte; busy_seen = 1'b0;
        for (int t = 0; t < 16; t++) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = ~sclk;
            repeat (4) begin @(negedge clk); busy_seen = busy_seen | busy; end
        end
        check("idle_sclk_rx", rx_byte, rx0);
        check("idle_sclk_pulses", n_pulses - p0, 0);
        check("idle_sclk_busy", busy_seen, 0);

        // abort after 3 bits, then a clean byte
        p0 = n_pulses;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(8'($urandom_range(0, 255)), 3, 1'b0, got);
        check("partial_busy", busy, 1);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        exp_err = 1'b1;
        repeat (12) @(negedge clk);
        check("partial_pulses", n_pulses - p0, 0);
        check("partial_err", frame_err, 1);
        check("partial_state", state_dbg, 2'd0);
        fm_q.delete(); ft_q.delete();
        fm_q.push_back(8'h3C); ft_q.push_back(8'($urandom_range(0, 255)));
        run_frame();

        // reset during bit 5; frame left running across release is ignored
        p0 = n_pulses;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        spi_bits(8'($urandom_range(0, 255)), 5, 1'b1, got);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        #1;
        check("mid_rst_rx", rx_byte, 8'h00);
        check("mid_rst_err", frame_err, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_miso", miso, 0);
        check("mid_rst_oe", miso_oe, 0);
        check("mid_rst_done", cycle_done, 0);
        repeat (2) @(negedge clk);
        sclk = 1'b0;
        rst = 1'b1;
        busy_seen = 1'b0;
        for (int t = 0; t < 16; t++) begin
            sclk = ~sclk;
            mosi = 1'($urandom_range(0, 1));
            repeat (8) begin @(negedge clk); busy_seen = busy_seen | busy | miso_oe; end
        end
        check("post_rst_ignored", busy_seen, 0);
        check("post_rst_pulses", n_pulses - p0, 0);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        fm_q.delete(); ft_q.delete();
        fm_q.push_back(8'h5A); ft_q.push_back(8'($urandom_range(0, 255)));
        run_frame();

        // reset while cycle_done is high drops it at once, no later pulse
        p0 = n_pulses;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        spi_bits(b, 8, 1'b1, got);
        for (int w = 0; w < 20 && !cycle_done; w++) @(negedge clk);
        check("done_seen", cycle_done, 1);
        #2;
        rst = 1'b0;
        #1;
        check("done_async_drop", cycle_done, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        sclk = 1'b0;
        rst = 1'b1;
        cs_n = 1'b1;
        repeat (30) @(negedge clk);
        check("done_rst_pulses", n_pulses - p0, 1);
        check("done_rst_level", cycle_done, 0);

        // one more random frame after recovery
        fm_q.delete(); ft_q.delete();
        fm_q.push_back(8'($urandom_range(0, 255))); fm_q.push_back(8'($urandom_range(0, 255)));
        ft_q.push_back(8'($urandom_range(0, 255))); ft_q.push_back(8'($urandom_range(0, 255)));
        run_frame();

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
